input_dma_controller: RTL and testbench

- Parametrised successor to the single-mode key DMA block: N raw async inputs pass through synchroniser + debouncer; on copy_start a coherent snapshot is burst-written into data memory at a base address.
- Adds packed (16 inputs/word) or replicated (1 input/word) layout, busy/done status and an optional press-event region.
- Sits beside the CPU/data-memory arbiter; owns the memory write port while busy.

---
 rtl/input_dma_pkg.sv | 17 +
 rtl/input_dma_controller_debouncer.sv | 45 ++++
 rtl/input_dma_controller.sv | 162 ++++++++++++++++
 tb/tb_input_dma_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/input_dma_pkg.sv
// rtl/input_dma_pkg.sv - shared FSM encoding, word width and layout sizing for input_dma_controller
package input_dma_pkg;

  localparam int WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } dma_state_e;

  // Words needed for one region: one per input, or 16 inputs per word when packed.
  function automatic int calc_words(input int count, input int packed_mode);
    return (packed_mode != 0) ? (count + WORD_WIDTH - 1) / WORD_WIDTH : count;
  endfunction

endpackage

// File: rtl/input_dma_controller_debouncer.sv
// rtl/input_dma_controller_debouncer.sv - two-flop synchroniser plus stability counter for one raw input
// A level change is accepted after DEBOUNCE_CYCLES consecutive differing samples.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;
  logic          settle;

  // settle marks the edge on which level will take the synchronised value
  assign settle = (sync1 != level) && (cnt == '0);
  assign rise   = settle && sync1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      level <= 1'b0;
      cnt   <= RELOAD;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      if (sync1 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level <= sync1;
        cnt   <= RELOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_dma_controller.sv
// rtl/input_dma_controller.sv - debounced input snapshot burst-written into data memory at BASE_ADDR
// Optional press-event region after the state words: define INPUT_DMA_EDGE_EVENTS_EN.
`ifndef KEY_NUM
`define KEY_NUM 4
`endif
`ifndef KEY_MEM
`define KEY_MEM 'h100
`endif
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 12
`endif

module input_dma_controller
  import input_dma_pkg::*;
#(
  parameter int INPUT_COUNT     = `KEY_NUM,
  parameter int BASE_ADDR       = `KEY_MEM,
  parameter int ADDR_WIDTH      = `DATA_ADDR_WIDTH,
  parameter int PACKED          = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   copy_start,
  input  logic [INPUT_COUNT-1:0] inputs_in,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_dout_we,
  output logic [ADDR_WIDTH-1:0]  mem_dout_addr,
  output logic [WORD_WIDTH-1:0]  mem_dout
);

  localparam int W = calc_words(INPUT_COUNT, PACKED);
`ifdef INPUT_DMA_EDGE_EVENTS_EN
  localparam int T = 2 * W;
`else
  localparam int T = W;
`endif
  localparam int IDX_W  = (T > 1) ? $clog2(T) : 1;
  localparam int NWORDS = 2 ** IDX_W;

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(T - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_COPY = COPY;
  localparam logic [1:0] S_DONE = DONE;

  if (INPUT_COUNT < 1 || INPUT_COUNT > 256) begin : g_bad_count
    $error("input_dma_controller: INPUT_COUNT must be 1..256");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("input_dma_controller: DEBOUNCE_CYCLES must be >= 1");
  end
  if (64'(BASE_ADDR) + 64'(T) - 64'd1 >= (64'd1 << ADDR_WIDTH)) begin : g_bad_range
    $error("input_dma_controller: burst does not fit in the address space");
  end

  logic [INPUT_COUNT-1:0] debounced;
  logic [INPUT_COUNT-1:0] rise;
  logic [INPUT_COUNT-1:0] snapshot;
  logic [1:0]             state;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [IDX_W-1:0]       idx;
  logic [WORD_WIDTH-1:0]  words [NWORDS];
  logic                   accept;

  // Highest input bit is slot 0, matching the legacy key ordering.
  for (genvar s = 0; s < INPUT_COUNT; s++) begin : g_slot
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk  (clk),
      .reset(reset),
      .raw  (inputs_in[INPUT_COUNT-1-s]),
      .level(debounced[s]),
      .rise (rise[s])
    );
  end

  assign accept = (state == S_IDLE) && copy_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      addr     <= FIRST_ADDR;
      idx      <= '0;
      snapshot <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (copy_start) begin
            state    <= S_COPY;
            snapshot <= debounced;
            addr     <= FIRST_ADDR;
            idx      <= '0;
          end
        end
        S_COPY: begin
          if (idx == LAST_IDX) begin
            state <= S_DONE;
            addr  <= FIRST_ADDR;
            idx   <= '0;
          end else begin
            addr <= addr + 1'b1;
            idx  <= idx + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef INPUT_DMA_EDGE_EVENTS_EN
  logic [INPUT_COUNT-1:0] press_flags;
  logic [INPUT_COUNT-1:0] event_snap;

  // A rise landing on the capture edge is kept for the following copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_flags <= '0;
      event_snap  <= '0;
    end else if (accept) begin
      event_snap  <= press_flags;
      press_flags <= rise;
    end else begin
      press_flags <= press_flags | rise;
    end
  end
`else
  logic unused_rise;
  logic unused_accept;
  assign unused_rise   = ^rise;
  assign unused_accept = accept;
`endif

  // State words first, then the event words in the same layout.
  for (genvar k = 0; k < NWORDS; k++) begin : g_word
    for (genvar b = 0; b < WORD_WIDTH; b++) begin : g_bit
      localparam int SLOT = (PACKED != 0) ? (k % W) * WORD_WIDTH + b : (k % W);
      if (k >= T || SLOT >= INPUT_COUNT) begin : g_zero
        assign words[k][b] = 1'b0;
      end else if (k < W) begin : g_state
        assign words[k][b] = snapshot[SLOT];
      end else begin : g_event
`ifdef INPUT_DMA_EDGE_EVENTS_EN
        assign words[k][b] = event_snap[SLOT];
`else
        assign words[k][b] = 1'b0;
`endif
      end
    end
  end

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign mem_dout_we   = (state == S_COPY);
  assign mem_dout_addr = addr;
  assign mem_dout      = (state == S_COPY) ? words[idx] : '0;

endmodule

// File: tb/tb_input_dma_controller.sv
// tb/tb_input_dma_controller.sv - scoreboard bench for replicated 4-input and packed 20-input controllers
module tb_input_dma_controller;

`ifdef INPUT_DMA_EDGE_EVENTS_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif
  localparam int T_R = EV ? 8 : 4;
  localparam int T_P = EV ? 4 : 2;
  localparam int P_R = T_R + 2;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_r = 1'b0;
  logic        cs_p = 1'b0;
  logic [3:0]  in_r = '0;
  logic [19:0] in_p = '0;
  logic        busy_r, done_r, we_r, busy_p, done_p, we_p;
  logic [11:0] addr_r, addr_p;
  logic [15:0] dout_r, dout_p;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q_r[$];
  exp_t q_p[$];
  exp_t mx_r, mx_p;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  input_dma_controller #(
    .INPUT_COUNT(4), .BASE_ADDR('h100), .ADDR_WIDTH(12), .PACKED(0), .DEBOUNCE_CYCLES(4)
  ) dut_r (
    .clk(clk), .reset(reset), .copy_start(cs_r), .inputs_in(in_r), .busy(busy_r),
    .done(done_r), .mem_dout_we(we_r), .mem_dout_addr(addr_r), .mem_dout(dout_r)
  );

  input_dma_controller #(
    .INPUT_COUNT(20), .BASE_ADDR('h200), .ADDR_WIDTH(12), .PACKED(1), .DEBOUNCE_CYCLES(4)
  ) dut_p (
    .clk(clk), .reset(reset), .copy_start(cs_p), .inputs_in(in_p), .busy(busy_p),
    .done(done_p), .mem_dout_we(we_p), .mem_dout_addr(addr_p), .mem_dout(dout_p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_r(input int e, input logic [3:0] raw, input logic [3:0] ev);
    exp_t x;
    for (int s = 0; s < 4; s++) begin
      x.cyc = e + s; x.addr = 12'h100 + 12'(s); x.data = raw[3-s] ? 16'hFFFF : 16'h0000;
      q_r.push_back(x);
    end
    if (EV) begin
      for (int s = 0; s < 4; s++) begin
        x.cyc = e + 4 + s; x.addr = 12'h104 + 12'(s); x.data = ev[3-s] ? 16'hFFFF : 16'h0000;
        q_r.push_back(x);
      end
    end
  endtask

  task automatic push_p(input int e, input logic [19:0] raw, input logic [19:0] ev);
    logic [31:0] w, v;
    exp_t x;
    w = '0; v = '0;
    for (int s = 0; s < 20; s++) begin
      w[s] = raw[19-s];
      v[s] = ev[19-s];
    end
    x.cyc = e;     x.addr = 12'h200; x.data = w[15:0];  q_p.push_back(x);
    x.cyc = e + 1; x.addr = 12'h201; x.data = w[31:16]; q_p.push_back(x);
    if (EV) begin
      x.cyc = e + 2; x.addr = 12'h202; x.data = v[15:0];  q_p.push_back(x);
      x.cyc = e + 3; x.addr = 12'h203; x.data = v[31:16]; q_p.push_back(x);
    end
  endtask

  task automatic copy_r(input logic [3:0] raw, input logic [3:0] ev);
    push_r(cyc + 1, raw, ev);
    cs_r = 1'b1; tick(1); cs_r = 1'b0;
    tick(T_R);
    check("r_done_pulse", 32'(done_r), 1);
    check("r_busy_in_done", 32'(busy_r), 1);
    tick(1);
    check("r_done_clear", 32'(done_r), 0);
    check("r_idle_after", 32'(busy_r), 0);
  endtask

  task automatic copy_p(input logic [19:0] raw, input logic [19:0] ev);
    push_p(cyc + 1, raw, ev);
    cs_p = 1'b1; tick(1); cs_p = 1'b0;
    tick(T_P);
    check("p_done_pulse", 32'(done_p), 1);
    tick(1);
    check("p_done_clear", 32'(done_p), 0);
    check("p_idle_after", 32'(busy_p), 0);
  endtask

  always @(negedge clk) begin
    if (we_r === 1'b1) begin
      if (q_r.size() == 0) check("r_unexpected_write", 32'(addr_r), 32'hFFFF_FFFF);
      else begin
        mx_r = q_r.pop_front();
        check("r_cyc", 32'(cyc), 32'(mx_r.cyc));
        check("r_addr", 32'(addr_r), 32'(mx_r.addr));
        check("r_data", 32'(dout_r), 32'(mx_r.data));
      end
    end
    if (we_p === 1'b1) begin
      if (q_p.size() == 0) check("p_unexpected_write", 32'(addr_p), 32'hFFFF_FFFF);
      else begin
        mx_p = q_p.pop_front();
        check("p_cyc", 32'(cyc), 32'(mx_p.cyc));
        check("p_addr", 32'(addr_p), 32'(mx_p.addr));
        check("p_data", 32'(dout_p), 32'(mx_p.data));
      end
    end
  end

  initial begin
    int e;
    tick(2);
    check("rst_busy_r", 32'(busy_r), 0);
    check("rst_done_r", 32'(done_r), 0);
    check("rst_we_r", 32'(we_r), 0);
    check("rst_addr_r", 32'(addr_r), 32'h100);
    check("rst_dout_r", 32'(dout_r), 0);
    check("rst_busy_p", 32'(busy_p), 0);
    check("rst_done_p", 32'(done_p), 0);
    check("rst_we_p", 32'(we_p), 0);
    check("rst_addr_p", 32'(addr_p), 32'h200);
    check("rst_dout_p", 32'(dout_p), 0);
    reset = 1'b0;
    tick(1);

    // replicated 1010 and packed slots 0,3,17
    in_r = 4'b1010;
    in_p = 20'h90004;
    tick(10);
    copy_r(4'b1010, 4'b1010);
    copy_p(20'h90004, 20'h90004);

    // debounce: 3-cycle glitch rejected, 6-cycle pulse accepted
    in_r = 4'b0000;
    in_p = 20'h00000;
    tick(10);
    in_r = 4'b0100; tick(3); in_r = 4'b0000;
    tick(10);
    copy_r(4'b0000, 4'b0000);
    in_r = 4'b0100; tick(6); in_r = 4'b0000;
    tick(2);
    copy_r(4'b0100, 4'b0100);

    // slot 2 pressed and released between packed copies
    tick(10);
    in_p = 20'h20000; tick(10); in_p = 20'h00000; tick(10);
    copy_p(20'h00000, 20'h20000);
    copy_p(20'h00000, 20'h00000);

    // copy_start held: back-to-back bursts, debounced change lands inside burst 0
    in_r = 4'b1010; tick(10);
    in_r = 4'b0110; tick(3);
    e = cyc + 1;
    for (int j = 0; j * P_R < 20; j++)
      push_r(e + j * P_R, (j == 0) ? 4'b1010 : 4'b0110,
             (j == 0) ? 4'b1010 : ((j == 1) ? 4'b0100 : 4'b0000));
    cs_r = 1'b1; tick(20); cs_r = 1'b0;
    tick(T_R + 4);
    check("held_idle", 32'(busy_r), 0);
    check("held_queue_drained", 32'(q_r.size()), 0);

    // reset after two writes of a burst
    push_r(cyc + 1, 4'b0110, 4'b0000);
    cs_r = 1'b1; tick(1); cs_r = 1'b0;
    tick(1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_we", 32'(we_r), 0);
    check("mid_rst_busy", 32'(busy_r), 0);
    check("mid_rst_addr", 32'(addr_r), 32'h100);
    check("mid_rst_done", 32'(done_r), 0);
    check("mid_rst_written", 32'(q_r.size()), 32'(T_R - 2));
    q_r.delete();
    tick(2);
    reset = 1'b0;
    tick(12);
    check("end_q_r_empty", 32'(q_r.size()), 0);
    check("end_q_p_empty", 32'(q_p.size()), 0);
    check("end_busy_r", 32'(busy_r), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
